// File: rtl/pool_stream_if.sv
// Valid/ready stream bundle used for both the sample input and the pooled-result output.
// The producer side uses the master modport; the consumer side uses slave.
interface pool_stream_if #(
   parameter int unsigned DWIDTH = 16
);
   logic              valid;
   logic [DWIDTH-1:0] data;
   logic              ready;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/pool_stream.sv
// Streaming window pooler: collects 2^(2*PLOG) signed samples and emits their max or floor average.
// Average pooling and the mode port exist only when POOL_AVG_EN is defined; otherwise max-only.
module pool_stream #(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned PLOG   = 1
) (
   input  logic clk,
   input  logic xrst,
   input  logic clear,
`ifdef POOL_AVG_EN
   input  logic mode,
`endif
   pool_stream_if.slave  in_if,
   pool_stream_if.master out_if,
   output logic busy
);

   localparam int unsigned CW = 2 * PLOG;
`ifdef POOL_AVG_EN
   // Wide enough to hold the sum of a full window without overflow.
   localparam int unsigned AW = DWIDTH + CW;
`else
   localparam int unsigned AW = DWIDTH;
`endif

   typedef enum logic {StAcc, StOut} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [DWIDTH-1:0]    out_data_q, out_data_d;

   logic                 in_xfer;
   logic                 first;
   logic                 last;
   logic signed [AW-1:0] sample_ext;
   logic signed [AW-1:0] max_val;
   logic signed [AW-1:0] next_acc;
   logic [DWIDTH-1:0]    result;

`ifdef POOL_AVG_EN
   logic                 mode_q, mode_d;
   logic signed [AW-1:0] sum_val;
   logic signed [AW-1:0] avg_val;
`endif

   assign in_if.ready  = (state_q == StAcc);
   assign out_if.valid = (state_q == StOut);
   assign out_if.data  = out_data_q;
   assign busy         = (state_q == StOut) || (cnt_q != '0);

   assign in_xfer    = in_if.valid && (state_q == StAcc) && !clear;
   assign first      = (cnt_q == '0);
   assign last       = &cnt_q;
   assign sample_ext = AW'($signed(in_if.data));
   assign max_val    = (sample_ext > acc_q) ? sample_ext : acc_q;

`ifdef POOL_AVG_EN
   assign sum_val  = acc_q + sample_ext;
   assign avg_val  = sum_val >>> CW;
   // Mode is latched with the first sample, so mid-window changes are ignored.
   assign next_acc = mode_q ? sum_val : max_val;
   assign result   = mode_q ? avg_val[DWIDTH-1:0] : max_val[DWIDTH-1:0];
`else
   assign next_acc = max_val;
   assign result   = max_val[DWIDTH-1:0];
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
`ifdef POOL_AVG_EN
      mode_d     = mode_q;
`endif
      unique case (state_q)
         StAcc: begin
            if (in_xfer) begin
               cnt_d = cnt_q + CW'(1);
               if (first) begin
                  acc_d = sample_ext;
`ifdef POOL_AVG_EN
                  mode_d = mode;
`endif
               end else begin
                  acc_d = next_acc;
               end
               if (last) begin
                  state_d    = StOut;
                  cnt_d      = '0;
                  out_data_d = result;
               end
            end
         end
         StOut: begin
            if (out_if.ready) begin
               state_d = StAcc;
            end
         end
         default: state_d = StAcc;
      endcase
      if (clear) begin
         state_d = StAcc;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q    <= StAcc;
         cnt_q      <= '0;
         acc_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
      end
   end

`ifdef POOL_AVG_EN
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         mode_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
      end
   end
`endif

endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream: driver pushes expected window results, monitor pops on handshake.
// Covers max pooling always; average-mode checks are included when POOL_AVG_EN is defined.
module tb_pool_stream;

   localparam int DW = 16;
   localparam int PL = 1;
   localparam int N  = 1 << (2 * PL);

   logic clk  = 1'b0;
   logic xrst = 1'b0;
   logic clear = 1'b0;
   logic busy;
`ifdef POOL_AVG_EN
   logic mode = 1'b0;
   int   win_mode;
`endif

   pool_stream_if #(.DWIDTH(DW)) in_if ();
   pool_stream_if #(.DWIDTH(DW)) out_if ();

   pool_stream #(
      .DWIDTH(DW),
      .PLOG  (PL)
   ) dut (
      .clk   (clk),
      .xrst  (xrst),
      .clear (clear),
`ifdef POOL_AVG_EN
      .mode  (mode),
`endif
      .in_if (in_if),
      .out_if(out_if),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int win[$];
   bit rand_ready = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: keep the window as a list, reduce it when full.
   function automatic void model_accept(input int v);
      int r;
      int s;
`ifdef POOL_AVG_EN
      if (win.size() == 0) win_mode = int'(mode);
`endif
      win.push_back(v);
      if (win.size() == N) begin
         r = win[0];
         foreach (win[i]) if (win[i] > r) r = win[i];
`ifdef POOL_AVG_EN
         if (win_mode == 1) begin
            s = 0;
            foreach (win[i]) s += win[i];
            r = s / N;
            if ((s % N) != 0 && s < 0) r--;
         end
`endif
         exp_q.push_back(r);
         win.delete();
      end
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge with valid left high.
   task automatic send(input int v);
      int t;
      t = 0;
      in_if.valid = 1'b1;
      in_if.data  = v[DW-1:0];
      while (!in_if.ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_if.ready) begin
         chk("in_ready_timeout", 0, 1);
         in_if.valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_accept(v);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rand_ready) out_if.ready = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      int e;
      #1;
      if (out_if.valid && out_if.ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", int'($signed(out_if.data)), e);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation ran out of time, got 0 expected 1");
      $fatal(1, "watchdog");
   end

   initial begin
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      out_if.ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", int'(out_if.valid), 0);
      chk("rst_out_data", int'(out_if.data), 0);
      chk("rst_busy", int'(busy), 0);
      xrst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", int'(in_if.ready), 1);

      // Basic max window, latency and return to accepting.
      send(3); send(-5); send(7); send(2);
      in_if.valid = 1'b0;
      chk("lat_out_valid", int'(out_if.valid), 1);
      chk("lat_out_data", int'($signed(out_if.data)), 7);
      chk("lat_in_ready_out", int'(in_if.ready), 0);
      @(negedge clk);
      chk("lat_in_ready_back", int'(in_if.ready), 1);

      // Signed comparison.
      send(-8); send(-3); send(-9); send(-4);
      in_if.valid = 1'b0;
      @(negedge clk);

      // Output backpressure with input still offered.
      out_if.ready = 1'b0;
      send(3); send(-5); send(7); send(2);
      in_if.data = 16'd99;
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", int'(in_if.ready), 0);
         chk("stall_out_valid", int'(out_if.valid), 1);
         chk("stall_out_data", int'($signed(out_if.data)), 7);
         chk("stall_busy", int'(busy), 1);
         @(negedge clk);
      end
      out_if.ready = 1'b1;
      in_if.valid  = 1'b0;
      @(negedge clk);
      chk("stall_release_in_ready", int'(in_if.ready), 1);
      chk("stall_release_out_valid", int'(out_if.valid), 0);

      // Clear discards a partial window.
      send(9); send(9);
      in_if.valid = 1'b0;
      chk("pre_clear_busy", int'(busy), 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      win.delete();
      chk("post_clear_busy", int'(busy), 0);
      send(1); send(1); send(1); send(1);
      in_if.valid = 1'b0;
      @(negedge clk);

`ifdef POOL_AVG_EN
      mode = 1'b1;
      send(1); send(2); send(3); send(-10);
      send(5); send(6); send(7); send(8);
      send(5);
      mode = 1'b0;
      send(6); send(7); send(8);
      send(-20);
      mode = 1'b1;
      send(6); send(-1); send(3);
      mode = 1'b0;
      in_if.valid = 1'b0;
      @(negedge clk);
`endif

      // Asynchronous reset mid-window.
      send(1); send(2); send(3);
      in_if.valid = 1'b0;
      chk("pre_rst_busy", int'(busy), 1);
      chk("pre_rst_out_data_nz", int'(out_if.data != '0), 1);
      #2 xrst = 1'b0;
      #1;
      chk("async_rst_out_valid", int'(out_if.valid), 0);
      chk("async_rst_out_data", int'(out_if.data), 0);
      chk("async_rst_busy", int'(busy), 0);
      win.delete();
      exp_q.delete();
      @(negedge clk);
      xrst = 1'b1;
      @(negedge clk);
      send(4); send(4); send(4); send(4);
      in_if.valid = 1'b0;
      @(negedge clk);

      // Randomized traffic with random backpressure, gaps, mode changes and clears.
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         int v;
         v = int'($urandom_range(0, 65535)) - 32768;
         if ($urandom_range(0, 3) == 0) v = v % 8;
`ifdef POOL_AVG_EN
         mode = 1'($urandom_range(0, 1));
`endif
         if ($urandom_range(0, 4) == 0) begin
            in_if.valid = 1'b0;
            @(negedge clk);
         end
         if ($urandom_range(0, 24) == 0 && !out_if.valid) begin
            in_if.valid = 1'b0;
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            win.delete();
            chk("rand_clear_busy", int'(busy), 0);
         end
         send(v);
      end
      in_if.valid = 1'b0;
      rand_ready  = 1'b0;
      out_if.ready = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain_pending", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pool_stream.md
POOL_STREAM -- requirements
Module: pool_stream

Interface
REQ-001 Parameter DWIDTH, default 16: signed data width of input and output samples.
REQ-002 Parameter PLOG, default 1, legal 1..3: log2 of window side; window holds N = 2^(2*PLOG) samples (4, 16 or 64).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 xrst  input  1  asynchronous active-low reset.
REQ-005 clear  input  1  synchronous abort of the current window, active-high.
REQ-006 mode  input  1  0 = max pool, 1 = average pool; port exists only with POOL_AVG_EN.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_data  input  DWIDTH  signed sample; window samples arrive serially.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 out_valid  output  1  out_data holds a completed window result.
REQ-011 out_data  output  DWIDTH  signed pooled result, registered.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 busy  output  1  high when a window is partially accumulated or a result is pending.

Function
REQ-014 Two states SHALL exist: ACC (collecting) and OUT (result pending); in_ready SHALL be 1 in ACC and 0 in OUT.
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1; a sample counter cnt (width 2*PLOG) SHALL increment per transfer.
REQ-016 The transfer with cnt==0 SHALL load the accumulator with the sample directly, ignoring the previous contents.
REQ-017 Max mode: later transfers SHALL replace the accumulator only if sample > accumulator (signed, strict); ties keep the held value.
REQ-018 Average mode: accumulator width SHALL be DWIDTH+2*PLOG, summing sign-extended samples without overflow.
REQ-019 On the transfer with cnt==N-1, the block SHALL enter OUT, reset cnt to 0, and register the result into out_data, so out_valid rises exactly one cycle after the last input transfer.
REQ-020 Average result SHALL be sum arithmetically shifted right by 2*PLOG (rounding toward minus infinity), truncated to DWIDTH.
REQ-021 In OUT, out_valid and out_data SHALL hold stable until out_ready is 1; the block then returns to ACC the next cycle.
REQ-022 Throughput SHALL be one window per N+1 cycles when in_valid and out_ready are held high.
REQ-023 mode SHALL be sampled on the cnt==0 transfer; changes mid-window SHALL have no effect until the next window.
REQ-024 clear SHALL override all handshakes: next state ACC, cnt=0, out_valid=0; a partial window SHALL produce no output.
REQ-025 busy SHALL equal (state==OUT) or (cnt!=0).

Reset
REQ-026 On xrst low, immediately and regardless of clk: state=ACC, cnt=0, accumulator=0, out_data=0, out_valid=0, busy=0; in_ready=1 after release.
REQ-027 Reset mid-window SHALL discard the partial window; the first transfer after release SHALL be treated as cnt==0.

Configuration
REQ-028 Macro POOL_AVG_EN: when defined, the mode port and the average datapath SHALL be present; when undefined, mode SHALL not exist, the block SHALL perform max pooling only, and the accumulator SHALL be DWIDTH bits.

Verification (DWIDTH=16, PLOG=1)
REQ-029 Samples 3,-5,7,2 back-to-back, out_ready=1 -> out_valid one cycle after the 4th transfer, out_data=7, in_ready high again the following cycle.
REQ-030 Samples -8,-3,-9,-4 -> out_data=-3 (signed compare), not -9 or an unsigned maximum.
REQ-031 Window 3,-5,7,2, out_ready=0 for 5 cycles with in_valid=1 -> out_valid=1 and out_data=7 held, in_ready=0, no samples consumed; out_ready=1 -> next window accepted from the following cycle.
REQ-032 Two samples 9,9, clear pulse, then 1,1,1,1 -> single output out_data=1; busy=0 the cycle after clear.
REQ-033 POOL_AVG_EN, mode=1: 1,2,3,-10 -> out_data=-1 (sum -4 >>> 2); 5,6,7,8 -> out_data=6 (26 >>> 2); mode toggled after the first sample of a window -> result unchanged.
REQ-034 xrst asserted after 3 samples, between clock edges -> out_valid, out_data and busy go to 0 without waiting for a clock edge; after release, 4,4,4,4 -> out_data=4.
